// File: rtl/beep_scheduler_pkg.sv
// ============================================================================
// Module      : beep_scheduler_pkg
// Description : Shared widths and FSM state encoding for the beep scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package beep_scheduler_pkg;

    localparam int TONE_W  = 11;
    localparam int DUR_W   = 16;
    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/beep_scheduler_ms_tick_gen.sv
// ============================================================================
// Module      : ms_tick_gen
// Description : Emits a one-cycle tick every TICKS cycles, phase set by clr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ms_tick_gen #(
    parameter int TICKS = 50_000
) (
    input  logic sclk,
    input  logic nrst,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W  = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge sclk) begin
        if (!nrst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/beep_scheduler.sv
// ============================================================================
// Module      : beep_scheduler
// Description : Fixed-priority arbiter sharing one tone datapath among three
//               requesters, with timed tones and a silent gap after each.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module beep_scheduler
    import beep_scheduler_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int GAP_MS   = 20
) (
    input  logic                        sclk,
    input  logic                        nrst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*TONE_W-1:0]   req_freq,
    input  logic [NUM_REQ*DUR_W-1:0]    req_dur_ms,
    input  logic                        abort,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          done,
    output logic [TONE_W-1:0]           tone_freq,
    output logic                        tone_en,
    output logic                        busy
);

    localparam int               TICKS      = CLK_FREQ / 1000;
    localparam logic [DUR_W-1:0] C_GAP_LAST = DUR_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);

    state_t               r_state;
    logic [DUR_W-1:0]     r_dur;
    logic [DUR_W-1:0]     r_ms;
    logic [NUM_REQ-1:0]   r_owner;
    logic                 r_zero_done;

    logic                 w_tick;
    logic                 w_clr;
    logic                 w_play_end;
    logic                 w_gap_end;
    logic [NUM_REQ-1:0]   w_gsel;
    logic [TONE_W-1:0]    w_gfreq;
    logic [DUR_W-1:0]     w_gdur;

    // Walk from the highest index down so the lowest set request wins.
    always_comb begin
        w_gsel  = '0;
        w_gfreq = '0;
        w_gdur  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_gsel    = '0;
                w_gsel[i] = 1'b1;
                w_gfreq   = req_freq[i*TONE_W +: TONE_W];
                w_gdur    = req_dur_ms[i*DUR_W +: DUR_W];
            end
        end
    end

    assign w_play_end = w_tick && (r_ms == r_dur - 1'b1);
    assign w_gap_end  = (GAP_MS == 0) || (w_tick && (r_ms == C_GAP_LAST));
    // Idle keeps both counters parked so every PLAY/GAP starts from zero.
    assign w_clr      = (r_state == ST_IDLE) || ((r_state == ST_PLAY) && w_play_end);

    ms_tick_gen #(
        .TICKS (TICKS)
    ) u_tick (
        .sclk  (sclk),
        .nrst  (nrst),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_ff @(posedge sclk) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_dur       <= '0;
            r_ms        <= '0;
            r_owner     <= '0;
            r_zero_done <= 1'b0;
            ack         <= '0;
            done        <= '0;
            tone_freq   <= '0;
            tone_en     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ack  <= '0;
            done <= '0;
            if (w_clr) begin
                r_ms <= '0;
            end else if (w_tick) begin
                r_ms <= r_ms + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!abort && (req != '0)) begin
                        r_owner <= w_gsel;
                        r_dur   <= w_gdur;
                        ack     <= w_gsel;
                        busy    <= 1'b1;
                        if (w_gdur != '0) begin
                            r_state     <= ST_PLAY;
                            tone_en     <= (w_gfreq != '0);
                            tone_freq   <= w_gfreq;
                            r_zero_done <= 1'b0;
                        end else begin
                            r_state     <= ST_GAP;
                            r_zero_done <= 1'b1;
                        end
                    end
                end
                ST_PLAY: begin
                    if (abort || w_play_end) begin
                        done      <= r_owner;
                        tone_en   <= 1'b0;
                        tone_freq <= '0;
                        if (abort || (GAP_MS == 0)) begin
                            r_state <= ST_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    // A zero-length tone reports done one cycle after its ack.
                    if (r_zero_done && !abort) begin
                        done <= r_owner;
                    end
                    r_zero_done <= 1'b0;
                    if (abort || w_gap_end) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_beep_scheduler.sv
// ============================================================================
// Module      : tb_beep_scheduler
// Description : Directed self-checking bench for beep_scheduler (TICKS=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_beep_scheduler;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        nrst;
    logic [2:0]  req, req_z;
    logic [32:0] req_freq, req_freq_z;
    logic [47:0] req_dur_ms, req_dur_ms_z;
    logic        abort, abort_z;
    logic [2:0]  ack, done, ack_z, done_z;
    logic [10:0] tone_freq, tone_freq_z;
    logic        tone_en, busy, tone_en_z, busy_z;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n, c1, c2, c3;
    logic bad;

    beep_scheduler #(.CLK_FREQ(10_000), .GAP_MS(2)) dut (
        .sclk(clk), .nrst(nrst), .req(req), .req_freq(req_freq),
        .req_dur_ms(req_dur_ms), .abort(abort), .ack(ack), .done(done),
        .tone_freq(tone_freq), .tone_en(tone_en), .busy(busy)
    );

    beep_scheduler #(.CLK_FREQ(10_000), .GAP_MS(0)) dut_z (
        .sclk(clk), .nrst(nrst), .req(req_z), .req_freq(req_freq_z),
        .req_dur_ms(req_dur_ms_z), .abort(abort_z), .ack(ack_z), .done(done_z),
        .tone_freq(tone_freq_z), .tone_en(tone_en_z), .busy(busy_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic set_req(input int i, input int f, input int d);
        req_freq[i*11 +: 11]   = 11'(f);
        req_dur_ms[i*16 +: 16] = 16'(d);
    endtask

    task automatic set_req_z(input int i, input int f, input int d);
        req_freq_z[i*11 +: 11]   = 11'(f);
        req_dur_ms_z[i*16 +: 16] = 16'(d);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0; req = '0; req_freq = '0; req_dur_ms = '0; abort = 1'b0;
        req_z = '0; req_freq_z = '0; req_dur_ms_z = '0; abort_z = 1'b0;
        step(); step();
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_freq", tone_freq, 0);
        check("rst_en", tone_en, 0);
        check("rst_busy", busy, 0);
        nrst = 1'b1;

        // Single tone: 440 Hz for 3 ms = 30 cycles, then 20 gap cycles.
        set_req(1, 440, 3); req = 3'b010;
        step();
        check("t1_ack", ack, 3'b010);
        check("t1_busy", busy, 1);
        req = '0;
        n = 0; bad = 1'b0;
        while (tone_en && n < 100) begin
            if (tone_freq !== 11'd440) bad = 1'b1;
            n++;
            step();
        end
        check("t1_len", n, 30);
        check("t1_freq_hold", bad, 0);
        check("t1_done", done, 3'b010);
        check("t1_freq_off", tone_freq, 0);
        wait_idle(n);
        check("t1_gap", n, 20);

        // Priority: req1 before req0 (raised mid-tone), req2 last.
        set_req(1, 300, 1); set_req(2, 500, 1); req = 3'b110;
        step(); c1 = cyc;
        check("pr_first", ack, 3'b010);
        check("pr_f1", tone_freq, 300);
        req[1] = 1'b0;
        step(); step();
        set_req(0, 100, 1); req[0] = 1'b1;
        n = 0;
        while (ack == 3'b000 && n < 100) begin step(); n++; end
        c2 = cyc;
        check("pr_second", ack, 3'b001);
        check("pr_delay0", c2 - c1, 31);
        check("pr_f0", tone_freq, 100);
        req[0] = 1'b0;
        step();
        n = 0;
        while (ack == 3'b000 && n < 100) begin step(); n++; end
        c3 = cyc;
        check("pr_third", ack, 3'b100);
        check("pr_delay2", c3 - c2, 31);
        check("pr_f2", tone_freq, 500);
        req[2] = 1'b0;
        wait_idle(n);

        // Rest: silent for 2 ms, then done.
        set_req(2, 0, 2); req = 3'b100;
        step();
        check("rs_ack", ack, 3'b100);
        check("rs_en", tone_en, 0);
        req = '0;
        n = 0; bad = 1'b0;
        while (done == 3'b000 && n < 100) begin
            if (tone_en) bad = 1'b1;
            step(); n++;
        end
        check("rs_len", n, 20);
        check("rs_done", done, 3'b100);
        check("rs_silent", bad, 0);
        wait_idle(n);

        // Zero duration: ack, done next cycle, then the gap.
        set_req(0, 700, 0); req = 3'b001;
        step();
        check("z_ack", ack, 3'b001);
        check("z_en", tone_en, 0);
        req = '0;
        step();
        check("z_done", done, 3'b001);
        check("z_en2", tone_en, 0);
        wait_idle(n);
        check("z_gap", n, 19);

        // Abort on cycle 5 of PLAY.
        set_req(1, 440, 3); req = 3'b010;
        step(); req = '0;
        step(); step(); step(); step();
        abort = 1'b1;
        step(); abort = 1'b0;
        check("ab_play_en", tone_en, 0);
        check("ab_play_done", done, 3'b010);
        check("ab_play_busy", busy, 0);

        // Abort during GAP: back to idle without done.
        set_req(1, 440, 1); req = 3'b010;
        step(); req = '0;
        n = 0;
        while (done == 3'b000 && n < 100) begin step(); n++; end
        check("ab_gap_tone", n, 10);
        step(); step();
        abort = 1'b1;
        step(); abort = 1'b0;
        check("ab_gap_busy", busy, 0);
        check("ab_gap_done", done, 0);
        step();
        check("ab_gap_done2", done, 0);

        // Abort in IDLE beats a same-cycle request.
        set_req(0, 440, 1); req = 3'b001; abort = 1'b1;
        step();
        check("ab_idle_ack", ack, 0);
        check("ab_idle_busy", busy, 0);
        abort = 1'b0;
        step();
        check("ab_idle_late_ack", ack, 3'b001);

        // Reset mid-PLAY with req still held, then re-ack after release.
        step(); step();
        nrst = 1'b0;
        step();
        check("rm_en", tone_en, 0);
        check("rm_freq", tone_freq, 0);
        check("rm_busy", busy, 0);
        check("rm_done", done, 0);
        nrst = 1'b1;
        step();
        check("rm_reack", ack, 3'b001);
        req = '0;
        wait_idle(n);

        // No-gap variant: next grant one cycle after the previous done.
        set_req_z(0, 440, 1); set_req_z(1, 440, 1); req_z = 3'b011;
        step(); c1 = cyc;
        check("g0_ack1", ack_z, 3'b001);
        req_z[0] = 1'b0;
        n = 0;
        while (done_z == 3'b000 && n < 100) begin step(); n++; end
        c2 = cyc;
        check("g0_done", done_z, 3'b001);
        check("g0_len", c2 - c1, 10);
        check("g0_idle", busy_z, 0);
        step(); c3 = cyc;
        check("g0_ack2", ack_z, 3'b010);
        check("g0_spacing", c3 - c2, 1);
        req_z = '0;
        n = 0;
        while (busy_z && n < 100) begin step(); n++; end
        check("g0_end", busy_z, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
